// File: rtl/trak_pkg.sv
// trak_pkg: shared types, output bit positions and the saturation helper
// for the trackball quadrature scheduler (trak_quad_sched, trak_axis).
// No ports; imported by the RTL files.
package trak_pkg;

  localparam int ACC_W_DEFAULT = 12;

  typedef logic signed [ACC_W_DEFAULT-1:0] acc_t;
  typedef logic signed [8:0]               delta_t;

  // Low bit of each duplicated pair in trakball_o:
  // {xdir,xdir,xclk,xclk,ydir,ydir,yclk,yclk}
  localparam int TB_XDIR = 6;
  localparam int TB_XCLK = 4;
  localparam int TB_YDIR = 2;
  localparam int TB_YCLK = 0;

  // Clamp a sign-extended sum into [-sat_max, +sat_max].
  function automatic int clamp_acc(input int sum, input int sat_max);
    if (sum > sat_max)       return sat_max;
    else if (sum < -sat_max) return -sat_max;
    else                     return sum;
  endfunction

endpackage

// File: rtl/trak_quad_sched_if.sv
// trak_quad_sched_if: groups the mouse-side inputs and trackball-side
// outputs of trak_quad_sched.
//   ps2_mouse[24:0] : hps_io mouse word (toggle, Y/X bytes, Y/X signs)
//   enable          : 0 discards packets and freezes stepping
//   flush           : one-cycle pulse clearing both accumulators
//   trakball_o[7:0] : {xdir,xdir,xclk,xclk,ydir,ydir,yclk,yclk}
//   busy_o          : either accumulator nonzero
// Handshake: there is no valid/ready pair; a packet is "valid" on the
// cycle ps2_mouse[24] differs from its previous value and is always
// accepted (or dropped by enable=0 / flush), never back-pressured.
interface trak_quad_sched_if;
  logic [24:0] ps2_mouse;
  logic        enable;
  logic        flush;
  logic [7:0]  trakball_o;
  logic        busy_o;

  modport master (output ps2_mouse, enable, flush, input trakball_o, busy_o);
  modport slave  (input ps2_mouse, enable, flush, output trakball_o, busy_o);
endinterface

// File: rtl/trak_axis.sv
// trak_axis: one axis of the scheduler -- signed saturating accumulator
// plus the direction/clock register of the quadrature output.
//   clk, reset : clock, synchronous active-high reset
//   flush      : clear accumulator (dir/clk hold, same-cycle packet lost)
//   add_en     : add delta this cycle
//   tick       : step tick; drains one count toward zero when acc != 0
//   delta      : sign-extended packet delta (ACC_W+1 bits)
//   acc_nxt_o  : next-state accumulator (for the registered busy flag)
//   dir_o/clk_o: quadrature direction level and toggling clock
module trak_axis
  import trak_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEFAULT,
  parameter int SAT_MAX = 2047
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    add_en,
  input  logic                    tick,
  input  logic signed [ACC_W:0]   delta,
  output logic signed [ACC_W-1:0] acc_nxt_o,
  output logic                    dir_o,
  output logic                    clk_o
);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    dir_q, dir_d;
  logic                    clk_q, clk_d;
  logic signed [ACC_W:0]   add_v, step_v, sum;
  logic                    stepping;

  always_comb begin
    // Step decision uses the pre-update accumulator; a flush suppresses it.
    stepping = tick && (acc_q != '0) && !flush;
    add_v    = add_en ? delta : '0;
    step_v   = '0;
    if (stepping) step_v = acc_q[ACC_W-1] ? '1 : (ACC_W+1)'(1);
    // One extra bit of headroom: sum never wraps before the clamp.
    sum      = {acc_q[ACC_W-1], acc_q} + add_v - step_v;
    acc_d    = flush ? '0 : ACC_W'(clamp_acc(int'(sum), SAT_MAX));
    dir_d    = dir_q;
    clk_d    = clk_q;
    if (stepping) begin
      dir_d = !acc_q[ACC_W-1];
      clk_d = !clk_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      dir_q <= 1'b0;
      clk_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      dir_q <= dir_d;
      clk_q <= clk_d;
    end
  end

  assign acc_nxt_o = acc_d;
  assign dir_o     = dir_q;
  assign clk_o     = clk_q;

endmodule

// File: rtl/trak_quad_sched.sv
// trak_quad_sched: converts PS/2 mouse motion packets into paced
// trackball quadrature steps (clk_sys domain).
//   clk_sys : system clock
//   reset   : synchronous active-high reset
//   bus     : trak_quad_sched_if.slave (ps2_mouse, enable, flush in;
//             trakball_o, busy_o out)
// Holds the step divider, packet detect and output packing; the two
// trak_axis instances do the accumulation.
// Optional: define TRAK_INVERT_Y_EN to negate the Y delta before
// accumulation (screen-down-positive for the upright cabinet).
module trak_quad_sched
  import trak_pkg::*;
#(
  parameter int ACC_W    = ACC_W_DEFAULT,
  parameter int STEP_DIV = 64,
  parameter int SAT_MAX  = 2047
) (
  input logic              clk_sys,
  input logic              reset,
  trak_quad_sched_if.slave bus
);

  localparam int DIV_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;

  logic             tog_q, tog_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             busy_q, busy_d;
  logic             pkt, tick, add_en;
  delta_t           dx_raw, dy_raw;
  logic signed [ACC_W:0]   dx, dy_ext, dy;
  logic signed [ACC_W-1:0] accx_nxt, accy_nxt;
  logic             xdir, xclk, ydir, yclk;
  logic             unused_ps2;

  assign unused_ps2 = ^{bus.ps2_mouse[7:6], bus.ps2_mouse[3:0]};

  always_comb begin
    tog_d  = bus.ps2_mouse[24];
    pkt    = bus.ps2_mouse[24] != tog_q;
    tick   = bus.enable && (div_q == DIV_W'(STEP_DIV - 1));
    div_d  = div_q;
    if (bus.enable) div_d = tick ? '0 : div_q + DIV_W'(1);
    add_en = pkt && bus.enable;
    dx_raw = {bus.ps2_mouse[4], bus.ps2_mouse[15:8]};
    dy_raw = {bus.ps2_mouse[5], bus.ps2_mouse[23:16]};
    dx     = {{(ACC_W-8){dx_raw[8]}}, dx_raw};
    dy_ext = {{(ACC_W-8){dy_raw[8]}}, dy_raw};
`ifdef TRAK_INVERT_Y_EN
    // -256 becomes +256, still representable in ACC_W+1 bits.
    dy     = -dy_ext;
`else
    dy     = dy_ext;
`endif
    busy_d = (accx_nxt != '0) || (accy_nxt != '0);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      // Capture the current toggle so reset release never looks like a packet.
      tog_q  <= bus.ps2_mouse[24];
      div_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      tog_q  <= tog_d;
      div_q  <= div_d;
      busy_q <= busy_d;
    end
  end

  trak_axis #(.ACC_W(ACC_W), .SAT_MAX(SAT_MAX)) u_x (
    .clk(clk_sys), .reset(reset), .flush(bus.flush), .add_en(add_en),
    .tick(tick), .delta(dx), .acc_nxt_o(accx_nxt), .dir_o(xdir), .clk_o(xclk)
  );

  trak_axis #(.ACC_W(ACC_W), .SAT_MAX(SAT_MAX)) u_y (
    .clk(clk_sys), .reset(reset), .flush(bus.flush), .add_en(add_en),
    .tick(tick), .delta(dy), .acc_nxt_o(accy_nxt), .dir_o(ydir), .clk_o(yclk)
  );

  always_comb begin
    bus.trakball_o = '0;
    bus.trakball_o[TB_XDIR +: 2] = {2{xdir}};
    bus.trakball_o[TB_XCLK +: 2] = {2{xclk}};
    bus.trakball_o[TB_YDIR +: 2] = {2{ydir}};
    bus.trakball_o[TB_YCLK +: 2] = {2{yclk}};
  end

  assign bus.busy_o = busy_q;

endmodule

// File: tb/tb_trak_quad_sched.sv
module tb_trak_quad_sched;

  localparam int STEP_DIV = 4;
  localparam int SAT_MAX  = 2047;
`ifdef TRAK_INVERT_Y_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk_sys = 1'b0;
  logic reset;
  always #5 clk_sys = ~clk_sys;

  trak_quad_sched_if bus();

  trak_quad_sched #(.ACC_W(12), .STEP_DIV(STEP_DIV), .SAT_MAX(SAT_MAX)) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .bus(bus)
  );

  // ---------------- counters / scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (integer arithmetic) ----------------
  int mx, my, mdiv;
  bit mtog, mxd, mxc, myd, myc, mbusy;

  function automatic int sgn(input int v);
    return (v > 0) ? 1 : -1;
  endfunction

  function automatic int clampi(input int v);
    if (v > SAT_MAX) return SAT_MAX;
    if (v < -SAT_MAX) return -SAT_MAX;
    return v;
  endfunction

  task automatic model_clk(input logic rst, input logic [24:0] m,
                           input logic en, input logic fl);
    bit pkt, tick;
    int dx, dy;
    if (rst) begin
      mx = 0; my = 0; mdiv = 0; mtog = m[24];
      mxd = 0; mxc = 0; myd = 0; myc = 0; mbusy = 0;
      return;
    end
    pkt  = (m[24] != mtog);
    mtog = m[24];
    tick = en && (mdiv == STEP_DIV - 1);
    if (en) mdiv = tick ? 0 : mdiv + 1;
    dx = m[4] ? int'(m[15:8]) - 256 : int'(m[15:8]);
    dy = m[5] ? int'(m[23:16]) - 256 : int'(m[23:16]);
    if (INV) dy = -dy;
    if (fl) begin
      mx = 0; my = 0;
    end else begin
      if (tick && mx != 0) begin mxd = (mx > 0); mxc = ~mxc; end
      if (tick && my != 0) begin myd = (my > 0); myc = ~myc; end
      mx = clampi(mx + ((pkt && en) ? dx : 0) - ((tick && mx != 0) ? sgn(mx) : 0));
      my = clampi(my + ((pkt && en) ? dy : 0) - ((tick && my != 0) ? sgn(my) : 0));
    end
    mbusy = (mx != 0) || (my != 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    logic [8:0] e;
    @(posedge clk_sys);
    model_clk(reset, bus.ps2_mouse, bus.enable, bus.flush);
    exp_q.push_back({mxd, mxd, mxc, mxc, myd, myd, myc, myc, mbusy});
    #1;
    e = exp_q.pop_front();
    check("model_out", int'({bus.trakball_o, bus.busy_o}), int'(e));
    check("model_accx", int'(dut.u_x.acc_q), mx);
    check("model_accy", int'(dut.u_y.acc_q), my);
  endtask

  task automatic send(input bit xs, input logic [7:0] xb,
                      input bit ys, input logic [7:0] yb);
    bus.ps2_mouse = {~bus.ps2_mouse[24], yb, xb, 2'b00, ys, xs, 4'h0};
    cycle();
  endtask

  task automatic do_reset(input bit tog);
    reset = 1'b1;
    bus.ps2_mouse = {tog, 24'h0};
    cycle();
    reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         xs;
    logic [7:0] xb;
    bit         ys;
    logic [7:0] yb;
    int         ex_tog;
    int         ey_tog;
    bit         ex_dir;
    bit         ey_dir;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0] snap;
    int n, xt, yt, last;

    vecs[0] = '{1'b0, 8'h03, 1'b0, 8'h00, 3,   0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 8'hFE, 1'b0, 8'h00, 2,   0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 8'h05, 0,   5, 1'b0, !INV};
    vecs[3] = '{1'b0, 8'h01, 1'b1, 8'hFD, 1,   3, 1'b1, INV};
    vecs[4] = '{1'b1, 8'h00, 1'b0, 8'h00, 256, 0, 1'b0, INV};

    bus.enable = 1'b1;
    bus.flush  = 1'b0;

    // Reset release with toggle high and no further toggle: stays idle.
    do_reset(1'b1);
    cycle();
    for (int i = 0; i < 40; i++) begin
      cycle();
      check("idle_trak", int'(bus.trakball_o), 0);
      check("idle_busy", int'(bus.busy_o), 0);
    end

    // Table: single packet from idle, drain fully, count toggles.
    for (int v = 0; v < 5; v++) begin
      xt = 0; yt = 0; n = 0; last = -1;
      snap = bus.trakball_o;
      send(vecs[v].xs, vecs[v].xb, vecs[v].ys, vecs[v].yb);
      check("busy_rise", int'(bus.busy_o), 1);
      do begin
        cycle();
        n++;
        if (bus.trakball_o[4] != snap[4]) begin
          xt++;
          if (last >= 0) check("x_interval", n - last, STEP_DIV);
          last = n;
        end
        if (bus.trakball_o[0] != snap[0]) yt++;
        snap = bus.trakball_o;
      end while (bus.busy_o && n < 5000);
      if (n >= 5000) check("drain_timeout", 0, 1);
      for (int k = 0; k < 3 * STEP_DIV; k++) begin
        cycle();
        if (bus.trakball_o[4] != snap[4]) xt++;
        if (bus.trakball_o[0] != snap[0]) yt++;
        snap = bus.trakball_o;
      end
      check("vec_xtog", xt, vecs[v].ex_tog);
      check("vec_ytog", yt, vecs[v].ey_tog);
      check("vec_xdir", int'(bus.trakball_o[7]), int'(vecs[v].ex_dir));
      check("vec_ydir", int'(bus.trakball_o[3]), int'(vecs[v].ey_dir));
      check("vec_busy_end", int'(bus.busy_o), 0);
    end

    // Saturation: twelve +255 packets back to back, then a full drain.
    for (int k = 0; k < 12; k++) begin
      send(1'b0, 8'hFF, 1'b0, 8'h00);
      check("sat_nonneg", int'(int'(dut.u_x.acc_q) >= 0), 1);
    end
    check("sat_accx", int'(dut.u_x.acc_q), SAT_MAX);
    xt = 0; n = 0;
    snap = bus.trakball_o;
    while (bus.busy_o && n < 10000) begin
      cycle();
      n++;
      if (bus.trakball_o[4] != snap[4]) xt++;
      snap = bus.trakball_o;
    end
    if (n >= 10000) check("sat_timeout", 0, 1);
    check("sat_drain_steps", xt, SAT_MAX);

    // Packet landing on a tick while accy = 1.
    do_reset(1'b0);
    send(1'b0, 8'h00, 1'b0, 8'h01);
    cycle();
    cycle();
    send(1'b0, 8'h00, 1'b0, 8'h05);
    check("tick_pkt_accy", int'(dut.u_y.acc_q), INV ? -5 : 5);
    check("tick_pkt_yclk", int'(bus.trakball_o[0]), 1);
    check("tick_pkt_ydir", int'(bus.trakball_o[3]), INV ? 0 : 1);

    // Flush mid-drain together with a packet.
    send(1'b0, 8'h0A, 1'b0, 8'h0A);
    for (int k = 0; k < 6; k++) cycle();
    snap = bus.trakball_o;
    bus.flush = 1'b1;
    send(1'b0, 8'h05, 1'b1, 8'hF0);
    bus.flush = 1'b0;
    check("flush_accx", int'(dut.u_x.acc_q), 0);
    check("flush_accy", int'(dut.u_y.acc_q), 0);
    check("flush_busy", int'(bus.busy_o), 0);
    check("flush_hold", int'(bus.trakball_o), int'(snap));
    for (int k = 0; k < 3 * STEP_DIV; k++) cycle();
    check("flush_after", int'(bus.trakball_o), int'(snap));
    check("flush_busy_after", int'(bus.busy_o), 0);

    // enable = 0: packet discarded, stepping frozen.
    send(1'b0, 8'h04, 1'b0, 8'h00);
    check("en_accx", int'(dut.u_x.acc_q), 4);
    snap = bus.trakball_o;
    bus.enable = 1'b0;
    send(1'b0, 8'h07, 1'b0, 8'h03);
    for (int k = 0; k < 10; k++) cycle();
    check("en_off_accx", int'(dut.u_x.acc_q), 4);
    check("en_off_accy", int'(dut.u_y.acc_q), 0);
    check("en_off_trak", int'(bus.trakball_o), int'(snap));
    bus.enable = 1'b1;
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;

    // Randomised traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      reset      = ($urandom_range(0, 499) == 0);
      bus.enable = ($urandom_range(0, 9) != 0);
      bus.flush  = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 7) == 0)
        bus.ps2_mouse = {~bus.ps2_mouse[24], 8'($urandom), 8'($urandom),
                         2'b00, 1'($urandom), 1'($urandom), 4'h0};
      cycle();
    end
    reset = 1'b0;
    bus.flush = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
